// File: rtl/div_sequencer_if.sv
// div_sequencer_if
// Handshake and result bundle between a divide requester (the pipeline) and
// the multi-cycle divider div_sequencer.
//
// Signals:
//   start       requester -> divider  begin a divide (sampled only when idle)
//   is_signed   requester -> divider  1 = DIV, 0 = DIVU
//   dividend    requester -> divider  32-bit dividend
//   divisor     requester -> divider  32-bit divisor
//   flush       requester -> divider  abort the operation in flight
//   busy        divider -> requester  high whenever the divider is not idle
//   done        divider -> requester  one-cycle pulse, results valid
//   quotient    divider -> requester  LO result
//   remainder   divider -> requester  HI result
//   div_by_zero divider -> requester  last completed op had a zero divisor
interface div_sequencer_if;
    logic        start;
    logic        is_signed;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_by_zero;

    modport master (
        output start, is_signed, dividend, divisor, flush,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, is_signed, dividend, divisor, flush,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/div_sequencer.sv
// substraction
// 32-bit subtractor computing a - b as a + ~b + 1.
//   a, b      in   operands
//   sum       out  a - b (mod 2^32)
//   cout      out  1 = no borrow (a >= b unsigned)
//   overflow  out  signed overflow of a - b
module substraction (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] sum,
    output logic        cout,
    output logic        overflow
);
    assign {cout, sum} = {1'b0, a} + {1'b0, ~b} + 33'd1;
    assign overflow    = (a[31] ^ b[31]) & (a[31] ^ sum[31]);
endmodule

// div_sequencer
// Multi-cycle restoring divider for MIPS DIV/DIVU. One quotient bit is
// produced per cycle; a single shared subtractor performs operand magnitude
// negation, the trial subtraction of each iteration and the final sign fix-up.
//   clk    in   clock, rising edge
//   rst_n  in   asynchronous active-low reset
//   bus    slave side of div_sequencer_if (start/operands/flush in,
//          busy/done/quotient/remainder/div_by_zero out)
// WIDTH must stay 32 to match the subtractor.
module div_sequencer #(
    parameter int              WIDTH    = 32,
    parameter logic [WIDTH-1:0] DBZ_QUOT = 32'hFFFF_FFFF
) (
    input  logic             clk,
    input  logic             rst_n,
    div_sequencer_if.slave   bus
);
    localparam int             CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE, NEG_A, NEG_B, ITER, FIX_Q, FIX_R, DONE
    } state_t;

    state_t           state, next_state;

    logic [WIDTH-1:0] dividend_reg, divisor_reg;
    logic             signed_reg, sign_q, sign_r;
    logic [WIDTH-1:0] q_reg, d_reg, r_reg;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] quotient_reg, remainder_reg;
    logic             dbz_reg;

    logic [WIDTH-1:0] sub_a, sub_b, sub_sum;
    logic             sub_cout;
    logic             sub_overflow_unused;

    logic [WIDTH:0]   rs;
    logic             take;

    logic             accept;

    substraction u_sub (
        .a        (sub_a),
        .b        (sub_b),
        .sum      (sub_sum),
        .cout     (sub_cout),
        .overflow (sub_overflow_unused)
    );

    // A request is only honoured in IDLE, and flush in the same cycle wins.
    assign accept = (state == IDLE) && bus.start && !bus.flush;

    // Partial remainder shifted left by one with the next dividend bit.
    // If the bit shifted out of R is set, rs exceeds 2^32 > D so the
    // subtraction is always taken regardless of the subtractor carry.
    assign rs   = {r_reg, q_reg[WIDTH-1]};
    assign take = rs[WIDTH] | sub_cout;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; flush overrides every non-idle transition.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept) next_state = (bus.divisor == '0) ? DONE : NEG_A;
            NEG_A:   next_state = NEG_B;
            NEG_B:   next_state = ITER;
            ITER:    if (cnt == CNT_LAST) next_state = FIX_Q;
            FIX_Q:   next_state = FIX_R;
            FIX_R:   next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
        if (bus.flush && state != IDLE) begin
            next_state = IDLE;
        end
    end

    // Shared subtractor operand selection. Every use other than the
    // iteration is a negation (0 - x).
    always_comb begin
        sub_a = '0;
        sub_b = '0;
        case (state)
            NEG_A: sub_b = dividend_reg;
            NEG_B: sub_b = divisor_reg;
            ITER: begin
                sub_a = rs[WIDTH-1:0];
                sub_b = d_reg;
            end
            FIX_Q: sub_b = q_reg;
            FIX_R: sub_b = r_reg;
            default: begin
                sub_a = '0;
                sub_b = '0;
            end
        endcase
    end

    // Datapath registers. Result registers only load on the divide-by-zero
    // accept or when FIX_R really advances to DONE (not flushed).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dividend_reg  <= '0;
            divisor_reg   <= '0;
            signed_reg    <= 1'b0;
            sign_q        <= 1'b0;
            sign_r        <= 1'b0;
            q_reg         <= '0;
            d_reg         <= '0;
            r_reg         <= '0;
            cnt           <= '0;
            quotient_reg  <= '0;
            remainder_reg <= '0;
            dbz_reg       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (bus.divisor == '0) begin
                            quotient_reg  <= DBZ_QUOT;
                            remainder_reg <= bus.dividend;
                            dbz_reg       <= 1'b1;
                        end else begin
                            dividend_reg <= bus.dividend;
                            divisor_reg  <= bus.divisor;
                            signed_reg   <= bus.is_signed;
                            sign_q       <= bus.is_signed & (bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1]);
                            sign_r       <= bus.is_signed & bus.dividend[WIDTH-1];
                        end
                    end
                end
                NEG_A: begin
                    q_reg <= (signed_reg && dividend_reg[WIDTH-1]) ? sub_sum : dividend_reg;
                end
                NEG_B: begin
                    d_reg <= (signed_reg && divisor_reg[WIDTH-1]) ? sub_sum : divisor_reg;
                    r_reg <= '0;
                    cnt   <= '0;
                end
                ITER: begin
                    r_reg <= take ? sub_sum : rs[WIDTH-1:0];
                    q_reg <= {q_reg[WIDTH-2:0], take};
                    cnt   <= cnt + CNT_W'(1);
                end
                FIX_Q: begin
                    if (sign_q) q_reg <= sub_sum;
                end
                FIX_R: begin
                    if (sign_r) r_reg <= sub_sum;
                    if (!bus.flush) begin
                        quotient_reg  <= q_reg;
                        remainder_reg <= sign_r ? sub_sum : r_reg;
                        dbz_reg       <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.busy        = (state != IDLE);
    assign bus.done        = (state == DONE);
    assign bus.quotient    = quotient_reg;
    assign bus.remainder   = remainder_reg;
    assign bus.div_by_zero = dbz_reg;
endmodule
